// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter with a small byte FIFO in front of the serializer.
// Bytes are popped at frame start, and back-to-back frames are sent with no idle gap.
module uart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 10417,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_data,
    input  logic       tx_en,
    output logic       tx_status,
    output logic       tx_busy,
    output logic       tx_overflow,
    output logic       txd
);
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW     = $clog2(CLKS_PER_BIT);
    localparam int unsigned One      = 1;
    localparam int unsigned BaudLastInt = CLKS_PER_BIT - 1;

    localparam logic [PtrW:0]   FullCount = FIFO_DEPTH[PtrW:0];
    localparam logic [PtrW:0]   CountOne  = One[PtrW:0];
    localparam logic [PtrW-1:0] PtrOne    = One[PtrW-1:0];
    localparam logic [CntW-1:0] BaudOne   = One[CntW-1:0];
    localparam logic [CntW-1:0] BaudLast  = BaudLastInt[CntW-1:0];

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [PtrW:0]   count_q;
    logic [CntW-1:0] baud_q;
    logic [2:0]      bit_idx_q;
    logic [7:0]      shift_q;
    logic            txd_q;
    logic            overflow_q;

    logic push;
    logic pop;
    logic baud_done;
    logic fifo_nonempty;

    // Status comes from the registered count only, so a same-cycle pop never
    // makes room for a push into a full FIFO.
    assign tx_status     = (count_q != FullCount);
    assign fifo_nonempty = (count_q != '0);
    assign push          = tx_en && tx_status;
    assign baud_done     = (baud_q == BaudLast);

    always_comb begin
        pop = 1'b0;
        unique case (state_q)
            StIdle:  pop = fifo_nonempty;
            StStop:  pop = baud_done && fifo_nonempty;
            default: pop = 1'b0;
        endcase
    end

    assign tx_busy     = (state_q != StIdle) || fifo_nonempty;
    assign tx_overflow = overflow_q;
    assign txd         = txd_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
            if (push && !pop) begin
                count_q <= count_q + CountOne;
            end else if (!push && pop) begin
                count_q <= count_q - CountOne;
            end
            if (tx_en && !tx_status) begin
                overflow_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            baud_q    <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            txd_q     <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    txd_q <= 1'b1;
                    if (pop) begin
                        shift_q <= mem_q[rd_ptr_q];
                        baud_q  <= '0;
                        txd_q   <= 1'b0;
                        state_q <= StStart;
                    end
                end
                StStart: begin
                    if (baud_done) begin
                        baud_q    <= '0;
                        bit_idx_q <= '0;
                        txd_q     <= shift_q[0];
                        state_q   <= StData;
                    end else begin
                        baud_q <= baud_q + BaudOne;
                    end
                end
                StData: begin
                    if (baud_done) begin
                        baud_q    <= '0;
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) begin
                            txd_q   <= 1'b1;
                            state_q <= StStop;
                        end else begin
                            txd_q <= shift_q[1];
                        end
                    end else begin
                        baud_q <= baud_q + BaudOne;
                    end
                end
                StStop: begin
                    if (baud_done) begin
                        baud_q <= '0;
                        if (pop) begin
                            shift_q <= mem_q[rd_ptr_q];
                            txd_q   <= 1'b0;
                            state_q <= StStart;
                        end else begin
                            txd_q   <= 1'b1;
                            state_q <= StIdle;
                        end
                    end else begin
                        baud_q <= baud_q + BaudOne;
                    end
                end
                default: begin
                    txd_q   <= 1'b1;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: pushed bytes are queued as expectations and a
// line monitor decodes txd at mid-bit and compares each received byte against the queue.
module tb_uart_tx_serializer;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_en;
    logic       tx_status;
    logic       tx_busy;
    logic       tx_overflow;
    logic       txd;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q[$];

    int         cyc = 0;
    int         frames = 0;
    int         start_prev = 0;
    int         start_last = 0;
    bit         mon_active = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] rx = 8'h00;

    uart_tx_serializer #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_en      (tx_en),
        .tx_status  (tx_status),
        .tx_busy    (tx_busy),
        .tx_overflow(tx_overflow),
        .txd        (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Line monitor: frame cycle 0 is the first negedge that sees the start bit low.
    initial begin
        int         bit_no;
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            cyc++;
            if (!reset) begin
                mon_active = 1'b0;
            end else if (!mon_active) begin
                if (txd === 1'b0) begin
                    mon_active = 1'b1;
                    mon_cnt    = 0;
                    frames++;
                    start_prev = start_last;
                    start_last = cyc;
                end
            end else begin
                mon_cnt++;
                if (mon_cnt % CPB == CPB / 2) begin
                    bit_no = mon_cnt / CPB;
                    if (bit_no == 0) begin
                        check("start_bit", 32'(txd), 32'h0);
                    end else if (bit_no <= 8) begin
                        rx[bit_no-1] = txd;
                    end else begin
                        check("stop_bit", 32'(txd), 32'h1);
                        if (exp_q.size() == 0) begin
                            check("unexpected_byte", 32'(rx), 32'h100);
                        end else begin
                            exp_b = exp_q.pop_front();
                            check("rx_byte", 32'(rx), 32'(exp_b));
                        end
                        mon_active = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout got running expected finished");
        $fatal(1, "global timeout");
    end

    task automatic push(input logic [7:0] b, input bit accept);
        @(negedge clk);
        tx_en   = 1'b1;
        tx_data = b;
        if (accept) exp_q.push_back(b);
    endtask

    task automatic stop_push();
        @(negedge clk);
        tx_en   = 1'b0;
        tx_data = 8'hEE;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || tx_busy || mon_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(n < budget), 32'h1);
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        bit all_high;
        int i;
        int guard;
        int frames_saved;

        reset   = 1'b0;
        tx_en   = 1'b0;
        tx_data = 8'h00;

        // 1: reset values and a quiet line
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_txd", 32'(txd), 32'h1);
        check("rst_status", 32'(tx_status), 32'h1);
        check("rst_busy", 32'(tx_busy), 32'h0);
        check("rst_overflow", 32'(tx_overflow), 32'h0);
        all_high = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (txd !== 1'b1) all_high = 1'b0;
        end
        check("idle_line_high", 32'(all_high), 32'h1);

        // 2: single byte, latency and busy timing
        push(8'hA5, 1'b1);
        stop_push();
        check("lat_busy", 32'(tx_busy), 32'h1);
        check("lat_txd_still_high", 32'(txd), 32'h1);
        @(negedge clk);
        check("lat_txd_fall", 32'(txd), 32'h0);
        repeat (39) @(negedge clk);
        check("busy_last_cycle", 32'(tx_busy), 32'h1);
        @(negedge clk);
        check("busy_drop", 32'(tx_busy), 32'h0);
        wait_drain("drain_single", 200);

        // 3: back-to-back frames must be contiguous
        push(8'h55, 1'b1);
        push(8'h0F, 1'b1);
        stop_push();
        wait_drain("drain_b2b", 400);
        check("b2b_gap", 32'(start_last - start_prev), 32'(10 * CPB));

        // 4: fill, then overflow
        for (int k = 1; k <= 5; k++) push(8'(k), 1'b1);
        @(negedge clk);
        check("full_status", 32'(tx_status), 32'h0);
        check("ovf_before", 32'(tx_overflow), 32'h0);
        tx_en   = 1'b1;
        tx_data = 8'h06;
        stop_push();
        check("ovf_set", 32'(tx_overflow), 32'h1);
        wait_drain("drain_full", 1000);
        check("ovf_sticky", 32'(tx_overflow), 32'h1);

        // 5: stream with flow control, pointers wrap
        do_reset();
        check("ovf_cleared", 32'(tx_overflow), 32'h0);
        i     = 0;
        guard = 0;
        while (i < 12 && guard < 2000) begin
            @(negedge clk);
            guard++;
            tx_en = 1'b0;
            if (tx_status) begin
                tx_en   = 1'b1;
                tx_data = 8'h10 + 8'(i);
                exp_q.push_back(8'h10 + 8'(i));
                i++;
            end
        end
        stop_push();
        check("wrap_all_pushed", 32'(i), 32'd12);
        wait_drain("drain_wrap", 2000);
        check("wrap_no_overflow", 32'(tx_overflow), 32'h0);

        // 6: reset in the middle of DATA bit 3 with two bytes queued
        push(8'hFF, 1'b1);
        push(8'hC3, 1'b1);
        push(8'h3C, 1'b1);
        stop_push();
        repeat (16) @(negedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        #1;
        check("midrst_txd", 32'(txd), 32'h1);
        check("midrst_status", 32'(tx_status), 32'h1);
        check("midrst_busy", 32'(tx_busy), 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        frames_saved = frames;
        repeat (100) @(negedge clk);
        check("midrst_no_frame", 32'(frames - frames_saved), 32'h0);
        check("midrst_line_high", 32'(txd), 32'h1);
        check("sb_left", 32'(exp_q.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
